lsq_mem_issue: RTL and testbench
================================

Name: lsq_mem_issue

Overview:
- Load/store queue stage directly upstream of the data memory interface in the out-of-order core.
- Accepts tagged load/store ops from the execute/issue stage and buffers them in program order.
- Drives one word-sized read or write per cycle into the memory interface.
- Returns tagged load data and store completions, with registered valid signals, to the writeback/commit logic.

Parameters:
- CORE, 0, core index; used in report output only.
- DATA_WIDTH, 32, data word width.
- ADDRESS_BITS, 20, memory word address width.
- TAG_BITS, 6, ROB/destination tag width.
- QUEUE_DEPTH, 4, queue entries; must be a power of 2 and ≥2.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous active-high reset.
- flush  in  1  drop all queued ops; suppress the in-flight load response.
- stall  in  1  inhibit issue of a new access.
- in_valid  in  1  op offered.
- in_ready  out  1  queue can accept; equals !full.
- in_is_store  in  1  1 = store, 0 = load.
- in_addr  in  ADDRESS_BITS  access address.
- in_data  in  DATA_WIDTH  store data; ignored for loads.
- in_tag  in  TAG_BITS  op tag.
- mem_read  out  1  read strobe to memory interface.
- mem_write  out  1  write strobe to memory interface.
- mem_address  out  ADDRESS_BITS  access address.
- mem_in_data  out  DATA_WIDTH  store data.
- mem_out_data  in  DATA_WIDTH  load data; combinationally valid while mem_read is high.
- resp_valid  out  1  one-cycle completion pulse.
- resp_is_store  out  1  completion type.
- resp_tag  out  TAG_BITS  completion tag.
- resp_data  out  DATA_WIDTH  load data; 0 for stores.
- report  in  1  print state on this cycle.

Behaviour:
- Reset (async): head, tail and count = 0; FSM = IDLE; all mem_* and resp_* outputs = 0; in_ready = 1.
- Queue: circular buffer with head/tail pointers of log2(QUEUE_DEPTH) bits that wrap naturally, plus a count of log2(QUEUE_DEPTH)+1 bits.
  - Push occurs when in_valid & in_ready & !flush.
  - Full: count == QUEUE_DEPTH. While full, in_ready = 0 even if a pop happens the same cycle.
- Issue FSM, two states:
  - IDLE: mem_read = mem_write = 0.
  - ACCESS: exactly one of mem_read/mem_write = 1; mem_address, mem_in_data and the captured tag/type come from registers.
- Issue condition: queue non-empty & !stall & !flush. When it holds, the head is popped and latched into the issue registers at the clock edge, and the FSM goes to ACCESS next cycle.
- From ACCESS: go back to ACCESS if the issue condition holds again (back-to-back, one access per cycle); otherwise go to IDLE.
- stall only blocks new issue. An access already in ACCESS completes regardless of stall.
- Latency: op pushed at cycle t into an empty queue with no stall:
  - popped at edge t+1;
  - mem strobe high during cycle t+1;
  - resp_valid high during cycle t+2.
  - In general, memory strobe is the cycle after pop and response is the cycle after the strobe.
- Response: at the end of each ACCESS cycle, register resp_valid = 1, resp_tag, resp_is_store, and resp_data = mem_out_data for loads or 0 for stores.
  - resp_valid is a single-cycle pulse per access.
  - resp_* hold their values when resp_valid = 0; only resp_valid is guaranteed to deassert.
- Flush:
  - count, head, tail → 0 at the next edge; a push in the same cycle is dropped.
  - An access in ACCESS during flush still strobes memory, so stores are committed.
  - A load response from that ACCESS is suppressed (resp_valid = 0).
  - A store response is still reported.
  - FSM → IDLE.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Ordering: strict FIFO; loads never bypass older stores.
- Reset mid-access: outputs go to reset values immediately; the access is abandoned.

Optional Feature:
- Macro: LSQ_PERF_COUNTERS_EN.
- Defined: 32-bit counters for loads issued, stores issued, stall cycles (non-empty & stall), and full cycles (!in_ready). All clear on reset; all are printed when report = 1.
- Undefined: no counters; report prints queue count, FSM state and head entry only.
- Port list is identical in both builds.

Decomposition:
- Shared package lsq_pkg:
  - FSM state encodings: IDLE = 1'b0, ACCESS = 1'b1.
  - Entry field width helper: entry width = 1 + ADDRESS_BITS + DATA_WIDTH + TAG_BITS.
- One natural sub-module: lsq_fifo, the parameterised circular buffer with push/pop/flush, count and full/empty.
- The FSM and response registers stay in lsq_mem_issue.

Test Plan:
- Single load, addr 0x00010, tag 5, memory returns 0xDEADBEEF → mem_read in cycle t+1 with mem_address 0x00010; resp_valid at t+2 with tag 5 and data 0xDEADBEEF.
- Store addr 0x00020 data 0x12345678 tag 3, then load 0x00020 tag 4 → mem_write then mem_read on consecutive cycles; load response data 0x12345678; responses arrive in order 3, 4.
- Push 4 ops with stall = 1 → in_ready = 0 after the 4th push and no mem strobe; release stall → four back-to-back strobes and four responses on consecutive cycles.
- Flush asserted while a load (tag 7) is in ACCESS and 2 ops are queued → mem_read still pulses; no resp for tag 7; count = 0 next cycle; the 2 queued ops are never issued.
- Full queue with simultaneous pop and in_valid → push refused (in_ready = 0); count goes 4 → 3.
- Assert reset asynchronously mid-ACCESS → mem_read, mem_write and resp_valid drop without a clock edge; in_ready = 1 afterwards.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue issue stage: issue FSM state
// encoding and the packed queue-entry width helper.
package lsq_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } lsq_state_t;

   // Queue entry layout, MSB first: {is_store, addr, data, tag}
   function automatic int entry_width(input int address_bits,
                                      input int data_width,
                                      input int tag_bits);
      return 1 + address_bits + data_width + tag_bits;
   endfunction

endpackage

// File: rtl/lsq_fifo.sv
// Circular buffer of queue entries with push/pop/flush. Pointers are
// log2(DEPTH) bits and wrap on their own, so DEPTH must be a power of two.
// Entry storage is not reset; only the pointers and count are.
module lsq_fifo
   import lsq_pkg::*;
#(
   parameter int WIDTH = 59,
   parameter int DEPTH = 4,
   localparam int PTR_BITS = $clog2(DEPTH)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   input  logic                push,
   input  logic                pop,
   input  logic [WIDTH-1:0]    push_data,
   output logic [WIDTH-1:0]    head_data,
   output logic [PTR_BITS:0]   count,
   output logic                full,
   output logic                empty
);

   logic [WIDTH-1:0]    entries [DEPTH];
   logic [PTR_BITS-1:0] head;
   logic [PTR_BITS-1:0] tail;

   // Entry write; a push during flush is dropped
   always_ff @(posedge clock) begin
      if (push && !flush) begin
         entries[tail] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush wins over push/pop
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   assign head_data = entries[head];
   assign full      = (count == (PTR_BITS+1)'(DEPTH));
   assign empty     = (count == '0);

endmodule

// File: rtl/lsq_mem_issue.sv
// Load/store queue stage feeding the data memory interface. Ops are queued
// in program order and issued one per cycle; each access produces a
// registered one-cycle response the cycle after its memory strobe.
// Build option: define LSQ_PERF_COUNTERS_EN to add load/store/stall/full
// event counters, printed alongside the state dump when report is high.
//
//   state  | meaning
//   IDLE   | no access on the memory interface this cycle
//   ACCESS | issue registers drive one read or write strobe this cycle
module lsq_mem_issue #(
   parameter int CORE         = 0,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20,
   parameter int TAG_BITS     = 6,
   parameter int QUEUE_DEPTH  = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    stall,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_is_store,
   input  logic [ADDRESS_BITS-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [TAG_BITS-1:0]     in_tag,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDRESS_BITS-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]   mem_in_data,
   input  logic [DATA_WIDTH-1:0]   mem_out_data,
   output logic                    resp_valid,
   output logic                    resp_is_store,
   output logic [TAG_BITS-1:0]     resp_tag,
   output logic [DATA_WIDTH-1:0]   resp_data,
   input  logic                    report
);

   import lsq_pkg::*;

   localparam int ENTRY_W  = entry_width(ADDRESS_BITS, DATA_WIDTH, TAG_BITS);
   localparam int CNT_BITS = $clog2(QUEUE_DEPTH) + 1;

   lsq_state_t state;
   lsq_state_t next_state;

   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CNT_BITS-1:0]     fifo_count;
   logic [ENTRY_W-1:0]      push_entry;
   logic [ENTRY_W-1:0]      head_entry;

   logic                    head_is_store;
   logic [ADDRESS_BITS-1:0] head_addr;
   logic [DATA_WIDTH-1:0]   head_data;
   logic [TAG_BITS-1:0]     head_tag;

   logic                    iss_is_store;
   logic [ADDRESS_BITS-1:0] iss_addr;
   logic [DATA_WIDTH-1:0]   iss_data;
   logic [TAG_BITS-1:0]     iss_tag;

   // Issue moves the head into the issue registers; flush blocks both
   // pushes and new issue so nothing survives past the flush edge.
   assign in_ready   = !fifo_full;
   assign fifo_push  = in_valid && !fifo_full && !flush;
   assign fifo_pop   = !fifo_empty && !stall && !flush;
   assign push_entry = {in_is_store, in_addr, in_data, in_tag};

   assign head_is_store = head_entry[ENTRY_W-1];
   assign head_addr     = head_entry[DATA_WIDTH+TAG_BITS +: ADDRESS_BITS];
   assign head_data     = head_entry[TAG_BITS +: DATA_WIDTH];
   assign head_tag      = head_entry[TAG_BITS-1:0];

   lsq_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .push_data (push_entry),
      .head_data (head_entry),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and memory strobes; ACCESS repeats while ops keep issuing
   always_comb begin
      next_state = IDLE;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      if (fifo_pop) begin
         next_state = ACCESS;
      end
      if (state == ACCESS) begin
         mem_read  = !iss_is_store;
         mem_write = iss_is_store;
      end
   end

   // Issue registers capture the popped head entry
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         iss_is_store <= 1'b0;
         iss_addr     <= '0;
         iss_data     <= '0;
         iss_tag      <= '0;
      end else if (fifo_pop) begin
         iss_is_store <= head_is_store;
         iss_addr     <= head_addr;
         iss_data     <= head_data;
         iss_tag      <= head_tag;
      end
   end

   assign mem_address = iss_addr;
   assign mem_in_data = iss_data;

   // Response register: a load flushed mid-access reports nothing, but a
   // store has already written memory so its completion is still returned.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resp_valid    <= 1'b0;
         resp_is_store <= 1'b0;
         resp_tag      <= '0;
         resp_data     <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (state == ACCESS && (iss_is_store || !flush)) begin
            resp_valid    <= 1'b1;
            resp_is_store <= iss_is_store;
            resp_tag      <= iss_tag;
            resp_data     <= iss_is_store ? '0 : mem_out_data;
         end
      end
   end

`ifdef LSQ_PERF_COUNTERS_EN
   logic [31:0] perf_loads;
   logic [31:0] perf_stores;
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_full_cycles;

   // Event counters: issued loads/stores, stalled non-empty cycles, full cycles
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_loads        <= '0;
         perf_stores       <= '0;
         perf_stall_cycles <= '0;
         perf_full_cycles  <= '0;
      end else begin
         if (fifo_pop && !head_is_store) begin
            perf_loads <= perf_loads + 32'd1;
         end
         if (fifo_pop && head_is_store) begin
            perf_stores <= perf_stores + 32'd1;
         end
         if (!fifo_empty && stall) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
         if (!in_ready) begin
            perf_full_cycles <= perf_full_cycles + 32'd1;
         end
      end
   end
`endif

`ifndef SYNTHESIS
   // State dump on request, simulation only
   always @(posedge clock) begin
      if (!reset && report) begin
         $display("lsq_mem_issue[%0d] count=%0d state=%s head: store=%0b addr=%h data=%h tag=%0d",
                  CORE, fifo_count, state.name(), head_is_store, head_addr, head_data, head_tag);
`ifdef LSQ_PERF_COUNTERS_EN
         $display("lsq_mem_issue[%0d] loads=%0d stores=%0d stall_cycles=%0d full_cycles=%0d",
                  CORE, perf_loads, perf_stores, perf_stall_cycles, perf_full_cycles);
`endif
      end
   end
`endif

endmodule

// File: tb/tb_lsq_mem_issue.sv
// Scoreboard bench for lsq_mem_issue. A queue-level reference model decides
// each cycle which op is on the memory interface and what each completion
// must carry; a separate monitor compares every resp_valid pulse against
// the expected-response queue.
module tb_lsq_mem_issue;

   localparam int DW    = 32;
   localparam int AW    = 20;
   localparam int TW    = 6;
   localparam int DEPTH = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          flush;
   logic          stall;
   logic          in_valid;
   logic          in_ready;
   logic          in_is_store;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;
   logic [TW-1:0] in_tag;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_in_data;
   logic [DW-1:0] mem_out_data;
   logic          resp_valid;
   logic          resp_is_store;
   logic [TW-1:0] resp_tag;
   logic [DW-1:0] resp_data;
   logic          report;

   lsq_mem_issue #(
      .CORE         (0),
      .DATA_WIDTH   (DW),
      .ADDRESS_BITS (AW),
      .TAG_BITS     (TW),
      .QUEUE_DEPTH  (DEPTH)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .flush         (flush),
      .stall         (stall),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_is_store   (in_is_store),
      .in_addr       (in_addr),
      .in_data       (in_data),
      .in_tag        (in_tag),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_in_data   (mem_in_data),
      .mem_out_data  (mem_out_data),
      .resp_valid    (resp_valid),
      .resp_is_store (resp_is_store),
      .resp_tag      (resp_tag),
      .resp_data     (resp_data),
      .report        (report)
   );

   always #5 clock = ~clock;

   // Memory behind the interface: 256 words, combinational read
   logic [DW-1:0] mem [256];
   assign mem_out_data = mem_read ? mem[mem_address[7:0]] : '0;
   always @(posedge clock) begin
      if (mem_write) mem[mem_address[7:0]] = mem_in_data;
   end

   typedef struct packed {
      logic          is_store;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [TW-1:0] tag;
   } op_t;

   typedef struct packed {
      logic          is_store;
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } resp_t;

   int      n_checks = 0;
   int      n_errors = 0;
   bit      model_en = 1'b0;
   op_t     model_q[$];
   resp_t   exp_q[$];
   logic [DW-1:0] model_mem [256];
   bit      acc_valid = 1'b0;
   op_t     acc_op;
   bit      m_push;
   bit      m_pop;
   resp_t   got;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of accepted ops plus the op currently on the
   // memory interface (the one popped at the previous edge).
   always @(negedge clock) begin
      if (model_en) begin
         check("in_ready", in_ready, model_q.size() < DEPTH);
         check("mem_read", mem_read, acc_valid && !acc_op.is_store);
         check("mem_write", mem_write, acc_valid && acc_op.is_store);
         if (acc_valid) begin
            check("mem_address", mem_address, acc_op.addr);
            if (acc_op.is_store) begin
               check("mem_in_data", mem_in_data, acc_op.data);
               model_mem[acc_op.addr[7:0]] = acc_op.data;
               exp_q.push_back('{is_store: 1'b1, tag: acc_op.tag, data: '0});
            end else if (!flush) begin
               exp_q.push_back('{is_store: 1'b0, tag: acc_op.tag, data: model_mem[acc_op.addr[7:0]]});
            end
         end
         m_push = in_valid && (model_q.size() < DEPTH) && !flush;
         m_pop  = (model_q.size() > 0) && !stall && !flush;
         acc_valid = m_pop;
         if (m_pop) acc_op = model_q.pop_front();
         if (flush) model_q.delete();
         else if (m_push) model_q.push_back('{is_store: in_is_store, addr: in_addr, data: in_data, tag: in_tag});
      end
   end

   // Monitor: every completion pulse must match the oldest expected response
   always @(negedge clock) begin
      if (model_en && resp_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_resp: got tag %0d store %0b, expected none at %0t", resp_tag, resp_is_store, $time);
         end else begin
            got = exp_q.pop_front();
            check("resp_tag", resp_tag, got.tag);
            check("resp_is_store", resp_is_store, got.is_store);
            check("resp_data", resp_data, got.data);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic offer(input bit st, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [TW-1:0] t);
      in_valid    = 1'b1;
      in_is_store = st;
      in_addr     = a;
      in_data     = d;
      in_tag      = t;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; stall = 1'b0; report = 1'b0;
      in_valid = 1'b0; in_is_store = 1'b0; in_addr = '0; in_data = '0; in_tag = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i]       = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
         model_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
      end
      mem[16]       = 32'hDEADBEEF;
      model_mem[16] = 32'hDEADBEEF;

      #12;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_mem_read", mem_read, 1'b0);
      check("rst_mem_write", mem_write, 1'b0);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_mem_address", mem_address, '0);
      tick();
      reset = 1'b0;
      model_en = 1'b1;
      tick();

      // Single load
      offer(1'b0, 20'h00010, '0, 6'd5);
      tick();
      in_valid = 1'b0;
      tick();
      check("ld_mem_read", mem_read, 1'b1);
      check("ld_mem_address", mem_address, 20'h00010);
      tick();
      check("ld_resp_valid", resp_valid, 1'b1);
      check("ld_resp_tag", resp_tag, 6'd5);
      check("ld_resp_data", resp_data, 32'hDEADBEEF);
      tick(); tick();

      // Store then load of the same word
      offer(1'b1, 20'h00020, 32'h12345678, 6'd3);
      tick();
      offer(1'b0, 20'h00020, '0, 6'd4);
      tick();
      in_valid = 1'b0;
      check("st_mem_write", mem_write, 1'b1);
      tick();
      check("st_ld_mem_read", mem_read, 1'b1);
      check("st_resp_tag", resp_tag, 6'd3);
      tick();
      check("stld_resp_valid", resp_valid, 1'b1);
      check("stld_resp_tag", resp_tag, 6'd4);
      check("stld_resp_data", resp_data, 32'h12345678);
      tick(); tick();

      // Fill the queue under stall, then pop while a push is offered at full
      stall = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         offer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, TW'(10 + i));
         tick();
      end
      in_valid = 1'b0;
      check("full_in_ready", in_ready, 1'b0);
      check("full_no_strobe", mem_read | mem_write, 1'b0);
      tick();
      stall = 1'b0;
      offer(1'b0, 20'h00001, '0, 6'd20);
      check("full_pop_in_ready", in_ready, 1'b0);
      tick();
      in_valid = 1'b0;
      check("after_pop_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 6; i++) tick();

      // Flush while a load is in ACCESS with two ops still queued
      stall = 1'b1;
      offer(1'b0, 20'h00040, '0, 6'd7);
      tick();
      offer(1'b1, 20'h00041, 32'hA5A5A5A5, 6'd8);
      tick();
      offer(1'b0, 20'h00041, '0, 6'd9);
      tick();
      in_valid = 1'b0;
      stall = 1'b0;
      tick();
      flush = 1'b1;
      check("flush_mem_read", mem_read, 1'b1);
      tick();
      flush = 1'b0;
      check("flush_no_resp", resp_valid, 1'b0);
      check("flush_no_strobe", mem_read | mem_write, 1'b0);
      for (int i = 0; i < 4; i++) tick();

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         in_valid    = ($urandom_range(0, 9) < 6);
         in_is_store = 1'($urandom_range(0, 1));
         in_addr     = AW'($urandom_range(0, 15));
         in_data     = $urandom;
         in_tag      = TW'($urandom_range(0, 63));
         stall       = ($urandom_range(0, 3) == 0);
         flush       = ($urandom_range(0, 19) == 0);
         report      = (c == 700);
         tick();
      end
      in_valid = 1'b0; stall = 1'b0; flush = 1'b0; report = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("drain_pending_resps", exp_q.size(), 0);

      // Asynchronous reset in the middle of a back-to-back access pair
      stall = 1'b1;
      offer(1'b0, 20'h00050, '0, 6'd11);
      tick();
      offer(1'b0, 20'h00051, '0, 6'd12);
      tick();
      in_valid = 1'b0;
      stall = 1'b0;
      tick();
      tick();
      check("pre_rst_mem_read", mem_read, 1'b1);
      check("pre_rst_resp_valid", resp_valid, 1'b1);
      model_en = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("arst_mem_read", mem_read, 1'b0);
      check("arst_mem_write", mem_write, 1'b0);
      check("arst_resp_valid", resp_valid, 1'b0);
      check("arst_in_ready", in_ready, 1'b1);
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_mem_read", mem_read, 1'b0);
      check("post_rst_resp_valid", resp_valid, 1'b0);
      check("post_rst_in_ready", in_ready, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
